// File: rtl/mul_sequencer_if.sv
// Handshake and result bus between a pipeline controller and the
// iterative shift-add multiplier sequencer.
interface mul_sequencer_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic            flush;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, flush, op_a, op_b, rd_in,
    input  busy, stall, done, result, rd_out
  );

  modport slave (
    input  start, flush, op_a, op_b, rd_in,
    output busy, stall, done, result, rd_out
  );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier: one multiplier bit per RUN cycle, which ends
// early once the remaining multiplier bits are all zero.
module mul_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  mul_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;
  logic [4:0]      tag_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] mcand_d;
  logic [XLEN-1:0] mplier_d;
  logic            start_ok;

  // A start is only taken outside RUN and never alongside a flush.
  assign start_ok = bus.start && (state_q != RUN) && !bus.flush;

  always_comb begin
    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      tag_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (bus.flush) begin
      // Flush drops the operation but leaves the last published result intact.
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            state_q  <= RUN;
            mcand_q  <= bus.op_a;
            mplier_q <= bus.op_b;
            acc_q    <= '0;
            tag_q    <= bus.rd_in;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (mplier_q != '0) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
          end else begin
            state_q  <= DONE;
            result_q <= acc_q;
            rd_out_q <= tag_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.stall  = (state_q == RUN) || start_ok;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and randomized checks of mul_sequencer against a product/latency
// reference computed from plain arithmetic.
module tb_mul_sequencer;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [XLEN-1:0] exp_res;
  logic [4:0]      exp_rd;

  mul_sequencer_if #(.XLEN(XLEN)) bus ();

  mul_sequencer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Cycle in which done appears when start is accepted in cycle 0.
  function automatic int lat_of(input logic [XLEN-1:0] b);
    int n = 0;
    for (int i = 0; i < XLEN; i++) if (b[i]) n = i + 1;
    return n + 2;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [4:0] rd, input bit prestarted, input bit noise,
                        input bit chain, input logic [XLEN-1:0] ca,
                        input logic [XLEN-1:0] cb, input logic [4:0] crd,
                        input bit flushd);
    int lat;
    logic [XLEN-1:0] prod;
    lat  = lat_of(b);
    prod = a * b;
    if (!prestarted) begin
      next_cycle();
      bus.start = 1'b1; bus.flush = 1'b0;
      bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
      @(negedge clk);
      chk1("stall_accept", bus.stall, 1'b1);
    end
    for (int c = 1; c <= lat; c++) begin
      next_cycle();
      if (c < lat) begin
        bus.start = noise; bus.flush = 1'b0;
        if (noise) begin
          bus.op_a = {$urandom(), $urandom()};
          bus.op_b = {$urandom(), $urandom()};
          bus.rd_in = 5'($urandom_range(0, 31));
        end
      end else begin
        bus.start = chain || flushd;
        bus.flush = flushd;
        if (chain) begin
          bus.op_a = ca; bus.op_b = cb; bus.rd_in = crd;
        end
      end
      @(negedge clk);
      chk1("done_timing", bus.done, (c == lat));
      chk1("busy", bus.busy, (c < lat));
      if (c < lat) begin
        chk1("stall_run", bus.stall, 1'b1);
        chk("result_hold_run", bus.result, exp_res);
      end
    end
    exp_res = prod;
    exp_rd  = rd;
    chk("result", bus.result, exp_res);
    chk("rd_out", 64'(bus.rd_out), 64'(exp_rd));
    chk1("stall_done", bus.stall, chain);
    if (!chain) begin
      next_cycle();
      bus.start = 1'b0; bus.flush = 1'b0;
      @(negedge clk);
      chk1("done_single", bus.done, 1'b0);
      chk1("idle_busy", bus.busy, 1'b0);
      chk("result_hold_idle", bus.result, exp_res);
    end
  endtask

  task automatic abort_op(input bit by_reset);
    next_cycle();
    bus.start = 1'b1; bus.op_a = 64'd6; bus.op_b = 64'd7; bus.rd_in = 5'd3;
    @(negedge clk);
    chk1("abort_stall_c0", bus.stall, 1'b1);
    next_cycle();
    bus.start = 1'b0;
    @(negedge clk);
    chk1("abort_busy_c1", bus.busy, 1'b1);
    next_cycle();
    if (by_reset) rst_n = 1'b0;
    else bus.flush = 1'b1;
    @(negedge clk);
    chk1("abort_busy_c2", bus.busy, 1'b1);
    next_cycle();
    rst_n = 1'b1; bus.flush = 1'b0;
    if (by_reset) begin
      exp_res = '0;
      exp_rd  = '0;
    end
    @(negedge clk);
    chk1("abort_busy_c3", bus.busy, 1'b0);
    chk1("abort_stall_c3", bus.stall, 1'b0);
    chk("abort_result", bus.result, exp_res);
    chk("abort_rd_out", 64'(bus.rd_out), 64'(exp_rd));
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      @(negedge clk);
      chk1("abort_no_done", bus.done, 1'b0);
    end
  endtask

  initial begin
    logic [XLEN-1:0] ra, rb;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
    exp_res = '0; exp_rd = '0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_stall", bus.stall, 1'b0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_rd_out", 64'(bus.rd_out), 64'd0);
    next_cycle();
    rst_n = 1'b1;

    run_op(64'd3, 64'd5, 5'd7, 0, 0, 0, '0, '0, '0, 0);
    run_op(64'h1234, 64'd0, 5'd2, 0, 0, 0, '0, '0, '0, 0);
    run_op('1, '1, 5'd9, 0, 0, 0, '0, '0, '0, 0);
    run_op(64'h8000_0000_0000_0000, 64'd2, 5'd4, 0, 0, 0, '0, '0, '0, 0);

    abort_op(1'b0);
    abort_op(1'b1);

    // Back-to-back: second operation starts in the first one's DONE cycle.
    run_op(64'd6, 64'd7, 5'd1, 0, 0, 1, 64'd2, 64'd3, 5'd2, 0);
    run_op(64'd2, 64'd3, 5'd2, 1, 0, 0, '0, '0, '0, 0);

    run_op(64'd6, 64'd7, 5'd5, 0, 1, 0, '0, '0, '0, 0);
    run_op(64'd9, 64'd11, 5'd6, 0, 0, 0, '0, '0, '0, 1);

    next_cycle();
    bus.start = 1'b1; bus.flush = 1'b1; bus.op_a = 64'd5; bus.op_b = 64'd5;
    @(negedge clk);
    chk1("start_flush_stall", bus.stall, 1'b0);
    next_cycle();
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk1("start_flush_busy", bus.busy, 1'b0);

    next_cycle();
    rst_n = 1'b0; bus.start = 1'b1;
    next_cycle();
    rst_n = 1'b1; bus.start = 1'b0;
    exp_res = '0; exp_rd = '0;
    @(negedge clk);
    chk1("rst_prio_busy", bus.busy, 1'b0);
    chk("rst_prio_result", bus.result, 64'd0);

    for (int i = 0; i < 20; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      run_op(ra, rb, 5'($urandom_range(0, 31)), 0, bit'($urandom_range(0, 1)),
             0, '0, '0, '0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter: XLEN, default 64, operand and result width.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset.
REQ-004 Port: start  input  1  request a multiply using op_a, op_b and rd_in from the same cycle.
REQ-005 Port: flush  input  1  cancel any in-flight operation (pipeline flush).
REQ-006 Port: op_a  input  XLEN  multiplicand.
REQ-007 Port: op_b  input  XLEN  multiplier.
REQ-008 Port: rd_in  input  5  destination register tag.
REQ-009 Port: busy  output  1  high while state is RUN.
REQ-010 Port: stall  output  1  pipeline stall request, combinational.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: result  output  XLEN  low XLEN bits of op_a*op_b, registered.
REQ-013 Port: rd_out  output  5  tag of the completed operation, registered.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, plus internal registers mcand, mplier, acc (XLEN each) and tag (5).
REQ-015 IDLE: start=1 SHALL load mcand=op_a, mplier=op_b, acc=0, tag=rd_in and go to RUN; start=0 SHALL stay in IDLE.
REQ-016 RUN with mplier!=0: when mplier[0]=1, acc SHALL become (acc+mcand) mod 2^XLEN; mcand<<=1 and mplier>>=1 every cycle; the state stays RUN.
REQ-017 RUN with mplier==0: no add; go to DONE; result<=acc and rd_out<=tag on that edge.
REQ-018 DONE SHALL last exactly one cycle with done=1.
REQ-019 DONE with start=1: accept the new operands as in REQ-015 (back-to-back), go to RUN. DONE with start=0: go to IDLE.
REQ-020 start SHALL be ignored while in RUN.
REQ-021 Latency: with start accepted in cycle 0 and N = 1 + index of op_b's highest set bit (N=0 for op_b=0), done SHALL assert in cycle N+2. Maximum is cycle XLEN+2.
REQ-022 stall SHALL equal (state==RUN) OR (start AND state!=RUN AND NOT flush).
REQ-023 busy SHALL equal (state==RUN).
REQ-024 done SHALL be 0 in IDLE and RUN.
REQ-025 result and rd_out SHALL change only on entry to DONE and hold their values otherwise.
REQ-026 All arithmetic SHALL be unsigned modulo 2^XLEN; signed operands yield the correct low XLEN bits.
REQ-027 flush=1 at a clock edge SHALL force state IDLE and acc=0, suppress any pending done, and not modify result or rd_out.
REQ-028 A start in the same cycle as flush SHALL be ignored.
REQ-029 flush in DONE SHALL not cancel the done pulse already visible in that cycle, but SHALL block a back-to-back start.

Reset
REQ-030 rst_n=0 at a clock edge SHALL set state=IDLE and clear mcand, mplier, acc, tag, result and rd_out to 0; done, busy and stall are 0 after that edge.
REQ-031 Reset SHALL take priority over flush and start.
REQ-032 Reset mid-RUN SHALL abort the operation with no done pulse.

Verification
REQ-033 op_a=3, op_b=5, rd_in=7, start in cycle 0 -> done=1 in cycle 5 only, result=15, rd_out=7, stall high cycles 0-4.
REQ-034 op_a=0x1234, op_b=0 -> done in cycle 2, result=0.
REQ-035 op_a=op_b=all-ones (XLEN=64) -> done in cycle 66, result=1. op_a=0x8000_0000_0000_0000, op_b=2 -> result=0 (wrap-around).
REQ-036 Start 6*7, flush in cycle 2 -> no done, state IDLE in cycle 3, result retains its previous value. Repeat with rst_n=0 in cycle 2 -> result=0, no done.
REQ-037 Back-to-back: 6*7 (rd 1), then start 2*3 (rd 2) in that op's DONE cycle -> result 42/rd 1 in cycle 5, then 6/rd 2 in cycle 9.
REQ-038 start asserted during RUN with different operands -> ignored; first result unaffected.
